// File: rtl/lse_accumulator_pkg.sv
// Shared constants and the log-sum-exp correction table for lse_accumulator.
// Provides the default sizes, the FSM state type and lse_corr().
package lse_accumulator_pkg;

    localparam int N_IN_DEF   = 10;
    localparam int DATA_W_DEF = 8;
    localparam int SUM_W_DEF  = 9;
    localparam int FRAC_BITS  = 2;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } lse_state_t;

    // Correction in LSBs for log2(1+2^-d) with d in quarter steps.
    function automatic logic [2:0] lse_corr(input logic [31:0] d);
        logic [2:0] c;
        unique case (1'b1)
            (d == 32'd0):                 c = 3'd4;
            (d >= 32'd1 && d <= 32'd2):   c = 3'd3;
            (d >= 32'd3 && d <= 32'd6):   c = 3'd2;
            (d >= 32'd7 && d <= 32'd13):  c = 3'd1;
            default:                      c = 3'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lse_accumulator_pair.sv
// One log-sum-exp fold step: sum = max(acc,x) + corr(|acc-x|), saturating.
// Ports: acc (running value), x (new score), first (start of vector), sum.
module lse_pair
    import lse_accumulator_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SUM_W  = SUM_W_DEF
) (
    input  logic [SUM_W-1:0]  acc,
    input  logic [DATA_W-1:0] x,
    input  logic              first,
    output logic [SUM_W-1:0]  sum
);

    logic [SUM_W-1:0] xe;
    logic [SUM_W-1:0] mx;
    logic [SUM_W-1:0] d;
    logic [SUM_W:0]   s;

    always_comb begin
        xe = SUM_W'(x);
        if (acc >= xe) begin
            mx = acc;
            d  = acc - xe;
        end else begin
            mx = xe;
            d  = xe - acc;
        end
        s = {1'b0, mx} + (SUM_W+1)'(lse_corr(32'(d)));
        if (first) begin
            sum = xe;
        end else if (s[SUM_W]) begin
            sum = '1;
        end else begin
            sum = s[SUM_W-1:0];
        end
    end

endmodule

// File: rtl/lse_accumulator.sv
// Serial log-sum-exp accumulator: folds N_IN scores, then holds result+scores.
// Ports: clk, rst, in_valid/in_ready/in_data, out_valid/out_ready, exp_sum, x_flat.
module lse_accumulator
    import lse_accumulator_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SUM_W  = SUM_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SUM_W-1:0]       exp_sum,
    output logic [N_IN*DATA_W-1:0] x_flat
);

    localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;

    lse_state_t        state_q;
    lse_state_t        state_d;
    logic [CW-1:0]     count_q;
    logic [SUM_W-1:0]  acc_q;
    logic [SUM_W-1:0]  acc_next;
    logic [DATA_W-1:0] slots [N_IN];
    logic              hs;
    logic              last;

    assign hs   = in_valid & in_ready;
    assign last = (count_q == CW'(N_IN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM:   if (hs && last) state_d = DONE;
            DONE:    if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
    end

    lse_pair #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_pair (
        .acc   (acc_q),
        .x     (in_data),
        .first (count_q == '0),
        .sum   (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            acc_q   <= '0;
        end else if (hs) begin
            count_q <= last ? '0 : count_q + 1'b1;
            acc_q   <= acc_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_IN; i++) begin
            if (rst) begin
                slots[i] <= '0;
            end else if (hs && count_q == CW'(i)) begin
                slots[i] <= in_data;
            end
        end
    end

    // The accumulator is frozen in DONE, so it doubles as the result register.
    assign exp_sum = acc_q;

    for (genvar g = 0; g < N_IN; g++) begin : g_pack
        assign x_flat[g*DATA_W +: DATA_W] = slots[g];
    end

endmodule

// File: tb/tb_lse_accumulator.sv
// Self-checking bench for lse_accumulator: vector table, corner sequences,
// and randomized vectors against a log-sum-exp reference model.
module tb_lse_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  exp_sum;
    logic [79:0] x_flat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lse_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_sum   (exp_sum),
        .x_flat    (x_flat)
    );

    typedef struct {
        string       nm;
        logic [79:0] xs;
        int          gap_mode;
        logic [8:0]  exp_v;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [79:0] got,
                       input logic [79:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp_v);
        end
    endtask

    function automatic int corr_ref(input int d);
        if (d == 0) return 4;
        if (d <= 2) return 3;
        if (d <= 6) return 2;
        if (d <= 13) return 1;
        return 0;
    endfunction

    function automatic int lse_ref(input logic [79:0] xs);
        int a;
        int x;
        int hi;
        int lo;
        a = int'(xs[7:0]);
        for (int i = 1; i < 10; i++) begin
            x  = int'(xs[i*8 +: 8]);
            hi = (a > x) ? a : x;
            lo = (a > x) ? x : a;
            a  = hi + corr_ref(hi - lo);
            if (a > 511) a = 511;
        end
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [79:0] xs, input int gap_mode,
                        input string nm);
        int n;
        for (int i = 0; i < 10; i++) begin
            n = 0;
            if (i > 0 && gap_mode == 1) n = 1;
            if (i > 0 && gap_mode == 2) n = ($urandom_range(0, 3) == 0) ? 1 : 0;
            for (int k = 0; k < n; k++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                tick();
            end
            chk({nm, " in_ready"}, 80'(in_ready), 80'd1);
            if (i == 9) chk({nm, " early_valid"}, 80'(out_valid), 80'd0);
            in_valid = 1'b1;
            in_data  = xs[i*8 +: 8];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input logic [79:0] xs, input int gap_mode,
                           input logic [8:0] exp_v, input string nm);
        feed(xs, gap_mode, nm);
        chk({nm, " latency"}, 80'(out_valid), 80'd1);
        chk({nm, " exp_sum"}, 80'(exp_sum), 80'(exp_v));
        chk({nm, " x_flat"}, x_flat, xs);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, " released"}, 80'(out_valid), 80'd0);
        chk({nm, " ready_back"}, 80'(in_ready), 80'd1);
    endtask

    initial begin
        logic [79:0] xs;
        logic [8:0]  hold_sum;
        logic [79:0] hold_x;

        tbl[0] = '{"zeros",     80'h0, 0, 9'd14};
        tbl[1] = '{"one_big",   80'hC8, 0, 9'd200};
        tbl[2] = '{"all_ff",    {10{8'hFF}}, 0, 9'd269};
        tbl[3] = '{"zeros_gap", 80'h0, 1, 9'd14};
        tbl[4] = '{"d13",       80'h0714, 0, 9'd21};
        tbl[5] = '{"d14",       80'h0614, 0, 9'd20};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst out_valid", 80'(out_valid), 80'd0);
        chk("rst in_ready", 80'(in_ready), 80'd1);
        chk("rst exp_sum", 80'(exp_sum), 80'd0);
        chk("rst x_flat", x_flat, 80'd0);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 6; t++) begin
            run_vec(tbl[t].xs, tbl[t].gap_mode, tbl[t].exp_v, tbl[t].nm);
        end

        // Result held under back-pressure while the producer keeps pushing.
        feed({10{8'h11}}, 0, "hold");
        hold_sum = exp_sum;
        hold_x   = x_flat;
        chk("hold exp_sum", 80'(hold_sum), 80'(lse_ref({10{8'h11}})));
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("hold in_ready", 80'(in_ready), 80'd0);
            chk("hold out_valid", 80'(out_valid), 80'd1);
            chk("hold stable_sum", 80'(exp_sum), 80'(hold_sum));
            chk("hold stable_x", x_flat, hold_x);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold release", 80'(out_valid), 80'd0);
        chk("hold accum", 80'(in_ready), 80'd1);
        run_vec(80'h0, 0, 9'd14, "after_hold");

        // Reset in the middle of a vector discards the partial scores.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst out_valid", 80'(out_valid), 80'd0);
        chk("midrst in_ready", 80'(in_ready), 80'd1);
        chk("midrst exp_sum", 80'(exp_sum), 80'd0);
        chk("midrst x_flat", x_flat, 80'd0);
        run_vec(80'hC8, 0, 9'd200, "after_rst");

        // Reset while the result is presented.
        feed({10{8'h03}}, 0, "donerst");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("donerst out_valid", 80'(out_valid), 80'd0);
        chk("donerst x_flat", x_flat, 80'd0);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 10; i++) begin
                xs[i*8 +: 8] = (r % 2 == 0) ? 8'($urandom_range(0, 24))
                                            : 8'($urandom);
            end
            feed(xs, 2, "rand");
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                tick();
                chk("rand wait_valid", 80'(out_valid), 80'd1);
            end
            chk("rand exp_sum", 80'(exp_sum), 80'(lse_ref(xs)));
            chk("rand x_flat", x_flat, xs);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("rand released", 80'(out_valid), 80'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
